// File: rtl/projector_point_sequencer.sv
// projector_point_sequencer
// Reads a point list from Beta shared memory. The list is a header word
// holding the point count, followed by one word per point. Each point is
// presented to the galvo/DAC stage over a valid/ready handshake and then
// held for a programmable number of dwell cycles.
module projector_point_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int          MAX_POINTS = 1024,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] dwell,
  output logic [31:0] beta_addr,
  output logic        beta_rd,
  input  logic [31:0] beta_dout,
  output logic [11:0] point_x,
  output logic [11:0] point_y,
  output logic        laser_on,
  output logic        point_valid,
  input  logic        point_ready,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HDR,
    S_WAIT_HDR,
    S_RD_PT,
    S_WAIT_PT,
    S_PRESENT,
    S_DWELL
  } state_t;

  // The wait counter is loaded with RD_LATENCY-1 so that each WAIT state
  // lasts exactly RD_LATENCY cycles and samples read data on its last edge.
  localparam int               LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
  localparam logic [31:0]      MAX_COUNT = 32'(MAX_POINTS);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [15:0]      count;
  logic [15:0]      idx;
  logic [15:0]      dwell_lat;
  logic [15:0]      dwell_cnt;

  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic        unused_bits;

  assign hdr_count   = beta_dout[15:0];
  assign hdr_bad     = (hdr_count == 16'd0) || ({16'd0, hdr_count} > MAX_COUNT);
  // Point words carry no meaning in bits 30:28.
  assign unused_bits = &{1'b0, beta_dout[30:28]};

  // Byte address of point i; plain 32-bit arithmetic, wraps silently.
  function automatic logic [31:0] point_addr(input logic [15:0] i);
    return BASE_ADDR + {14'd0, i, 2'b00} + 32'd4;
  endfunction

  // Sequencer FSM with every output registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      lat_cnt     <= '0;
      count       <= '0;
      idx         <= '0;
      dwell_lat   <= '0;
      dwell_cnt   <= '0;
      beta_addr   <= '0;
      beta_rd     <= 1'b0;
      point_x     <= '0;
      point_y     <= '0;
      laser_on    <= 1'b0;
      point_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the strobe defaults below
      // are overridden later in the same block, which makes beta_rd, done
      // and error single-cycle pulses without any extra clear logic.
      beta_rd <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;

      if (stop) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        point_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_RD_HDR;
              beta_rd   <= 1'b1;
              beta_addr <= BASE_ADDR;
              busy      <= 1'b1;
              dwell_lat <= dwell;
            end
          end

          S_RD_HDR: begin
            state   <= S_WAIT_HDR;
            lat_cnt <= LAT_LOAD;
          end

          S_WAIT_HDR: begin
            if (lat_cnt != '0) begin
              lat_cnt <= lat_cnt - 1'b1;
            end else if (hdr_bad) begin
              state <= S_IDLE;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= S_RD_PT;
              count     <= hdr_count;
              idx       <= '0;
              beta_rd   <= 1'b1;
              beta_addr <= point_addr(16'd0);
            end
          end

          S_RD_PT: begin
            state   <= S_WAIT_PT;
            lat_cnt <= LAT_LOAD;
          end

          S_WAIT_PT: begin
            if (lat_cnt != '0) begin
              lat_cnt <= lat_cnt - 1'b1;
            end else begin
              state       <= S_PRESENT;
              laser_on    <= beta_dout[31];
              point_x     <= beta_dout[27:16];
              point_y     <= beta_dout[11:0];
              point_valid <= 1'b1;
            end
          end

          S_PRESENT: begin
            if (point_ready) begin
              state       <= S_DWELL;
              point_valid <= 1'b0;
              // A zero dwell still spends one cycle in DWELL.
              dwell_cnt   <= (dwell_lat == 16'd0) ? 16'd0 : dwell_lat - 16'd1;
            end
          end

          S_DWELL: begin
            if (dwell_cnt != 16'd0) begin
              dwell_cnt <= dwell_cnt - 16'd1;
            end else if (idx == count - 16'd1) begin
              state <= S_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= S_RD_PT;
              idx       <= idx + 16'd1;
              beta_rd   <= 1'b1;
              beta_addr <= point_addr(idx + 16'd1);
            end
          end

          default: begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            point_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_projector_point_sequencer.sv
// Testbench for projector_point_sequencer.
// Main instance uses RD_LATENCY=2 at 0x400. A second instance uses
// RD_LATENCY=1 with its list placed just below 2^32 so point addresses wrap.
// Inputs change 2 time units after the rising edge; outputs are sampled on
// the falling edge. Cycle labels name the rising edge that begins a cycle.
module tb_projector_point_sequencer;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;
  localparam int          MAXP  = 1024;
  localparam int          LAT   = 2;
  localparam int          MEMW  = 1026;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] dwell = 16'd0;
  logic        point_ready = 1'b1;
  logic [31:0] beta_addr, beta_dout;
  logic        beta_rd;
  logic [11:0] point_x, point_y;
  logic        laser_on, point_valid, busy, done, error;

  logic        start1 = 1'b0;
  logic        stop1 = 1'b0;
  logic [15:0] dwell1 = 16'd0;
  logic        ready1 = 1'b1;
  logic [31:0] beta_addr1, beta_dout1;
  logic        beta_rd1;
  logic [11:0] point_x1, point_y1;
  logic        laser_on1, point_valid1, busy1, done1, error1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  projector_point_sequencer #(.BASE_ADDR(BASE), .MAX_POINTS(MAXP), .RD_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .dwell(dwell),
    .beta_addr(beta_addr), .beta_rd(beta_rd), .beta_dout(beta_dout),
    .point_x(point_x), .point_y(point_y), .laser_on(laser_on),
    .point_valid(point_valid), .point_ready(point_ready),
    .busy(busy), .done(done), .error(error)
  );

  projector_point_sequencer #(.BASE_ADDR(BASE1), .MAX_POINTS(MAXP), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .stop(stop1), .dwell(dwell1),
    .beta_addr(beta_addr1), .beta_rd(beta_rd1), .beta_dout(beta_dout1),
    .point_x(point_x1), .point_y(point_y1), .laser_on(laser_on1),
    .point_valid(point_valid1), .point_ready(ready1),
    .busy(busy1), .done(done1), .error(error1)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Cycle label counter.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- memory models ----------------
  logic [31:0] mem [MEMW];
  logic [31:0] mem1 [4];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off[1:0] == 2'b00 && off < 32'(4 * MEMW)) return mem[int'(off[31:2])];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] mem1_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE1;
    if (off[1:0] == 2'b00 && off < 32'd16) return mem1[int'(off[3:2])];
    return 32'hDEAD_BEEF;
  endfunction

  // Read pipelines: depth equals each instance's read latency; not reset,
  // so data already in flight still arrives after a reset.
  logic [31:0] pa0 = '0, pa1 = '0, pb0 = '0;
  logic        pv0 = 1'b0, pv1 = 1'b0, pw0 = 1'b0;
  always @(posedge clk) begin
    pv0 <= beta_rd;  pa0 <= beta_addr;
    pv1 <= pv0;      pa1 <= pa0;
    pw0 <= beta_rd1; pb0 <= beta_addr1;
  end
  assign beta_dout  = pv1 ? mem_rd(pa1)  : 32'hDEAD_BEEF;
  assign beta_dout1 = pw0 ? mem1_rd(pb0) : 32'hDEAD_BEEF;

  // ---------------- monitors ----------------
  int          rd_cyc[$];
  logic [31:0] rd_addr[$];
  logic [31:0] acc_pt[$];
  int          acc_cyc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  int          valid_cnt = 0;
  int          acc_count = 0;
  logic [31:0] held = '0;
  logic        was_stalled = 1'b0;

  // Log reads, acceptances and pulses of the main instance; check that a
  // stalled point keeps its fields and that busy drops with done/error.
  always @(negedge clk) begin
    if (beta_rd) begin
      rd_cyc.push_back(cyc);
      rd_addr.push_back(beta_addr);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      check("busy low with done", 32'(busy), 32'd0);
    end
    if (error) begin
      err_cyc.push_back(cyc);
      check("busy low with error", 32'(busy), 32'd0);
    end
    if (point_valid) begin
      valid_cnt++;
      if (was_stalled) check("fields held while stalled", 32'({laser_on, point_x, point_y}), held);
      held = 32'({laser_on, point_x, point_y});
      if (point_ready) begin
        acc_pt.push_back(held);
        acc_cyc.push_back(cyc);
        acc_count++;
      end
    end
    was_stalled = point_valid && !point_ready;
  end

  int          rd1_cyc[$];
  logic [31:0] rd1_addr[$];
  int          acc1_cyc[$];
  logic [31:0] acc1_pt[$];
  int          done1_cyc[$];

  // Log activity of the latency-1 instance.
  always @(negedge clk) begin
    if (beta_rd1) begin
      rd1_cyc.push_back(cyc);
      rd1_addr.push_back(beta_addr1);
    end
    if (point_valid1 && ready1) begin
      acc1_cyc.push_back(cyc);
      acc1_pt.push_back(32'({laser_on1, point_x1, point_y1}));
    end
    if (done1) done1_cyc.push_back(cyc);
  end

  // Ready driver: hold point_ready low for stall_tab[i] cycles on point i.
  int stall_tab [MEMW];
  int stall_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (point_valid && stall_cnt < stall_tab[acc_count]) begin
      point_ready = 1'b0;
      stall_cnt++;
    end else begin
      point_ready = 1'b1;
      if (!point_valid) stall_cnt = 0;
    end
  end

  task automatic clear_logs();
    rd_cyc.delete(); rd_addr.delete(); acc_pt.delete(); acc_cyc.delete();
    done_cyc.delete(); err_cyc.delete();
    valid_cnt = 0;
    acc_count = 0;
    stall_cnt = 0;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < MEMW; i++) stall_tab[i] = 0;
  endtask

  // Play one list on the main instance and compare the logged transactions
  // with a timeline computed from the period rules:
  // header read at T, error at T+L+1; point i costs 1+L+1+stall+max(D,1).
  task automatic run_list(input string tag, input logic [31:0] hdr, input logic [15:0] d,
                          output int n_err, output int n_done);
    int T, t, acc_t, limit, cnt, dd, nv;
    logic legal;
    logic [31:0] w;
    mem[0] = hdr;
    clear_logs();
    cnt   = int'(hdr[15:0]);
    legal = (cnt != 0) && (cnt <= MAXP);
    dd    = (d == 16'd0) ? 1 : int'(d);
    dwell = d;
    step();
    start = 1'b1;
    T = cyc + 1;
    step();
    start = 1'b0;
    limit = 200 + (legal ? cnt : 0) * (LAT + 16 + dd);
    for (int k = 0; k < limit && busy; k++) step();
    check({tag, " finished within budget"}, 32'(busy), 32'd0);
    repeat (3) step();
    n_err  = err_cyc.size();
    n_done = done_cyc.size();

    check({tag, " read count"}, 32'(rd_addr.size()), legal ? 32'(cnt + 1) : 32'd1);
    if (rd_addr.size() > 0) begin
      check({tag, " header addr"}, rd_addr[0], BASE);
      check({tag, " header read cycle"}, 32'(rd_cyc[0]), 32'(T));
    end
    if (!legal) begin
      check({tag, " error count"}, 32'(err_cyc.size()), 32'd1);
      if (err_cyc.size() > 0) check({tag, " error cycle"}, 32'(err_cyc[0]), 32'(T + LAT + 1));
      check({tag, " done count"}, 32'(done_cyc.size()), 32'd0);
      check({tag, " valid cycles"}, 32'(valid_cnt), 32'd0);
    end else begin
      nv = 0;
      t  = T + LAT + 1;
      for (int i = 0; i < cnt; i++) begin
        w     = mem[i + 1];
        acc_t = t + LAT + 1 + stall_tab[i];
        if (i + 1 < rd_addr.size()) begin
          check({tag, $sformatf(" pt%0d addr", i)}, rd_addr[i + 1], BASE + 32'(4 * (i + 1)));
          check({tag, $sformatf(" pt%0d read cycle", i)}, 32'(rd_cyc[i + 1]), 32'(t));
        end
        if (i < acc_pt.size()) begin
          check({tag, $sformatf(" pt%0d fields", i)}, acc_pt[i], 32'({w[31], w[27:16], w[11:0]}));
          check({tag, $sformatf(" pt%0d accept cycle", i)}, 32'(acc_cyc[i]), 32'(acc_t));
        end
        nv += stall_tab[i] + 1;
        t = acc_t + 1 + dd;
      end
      check({tag, " accepted count"}, 32'(acc_pt.size()), 32'(cnt));
      check({tag, " valid cycles"}, 32'(valid_cnt), 32'(nv));
      check({tag, " error count"}, 32'(err_cyc.size()), 32'd0);
      check({tag, " done count"}, 32'(done_cyc.size()), 32'd1);
      if (done_cyc.size() > 0) check({tag, " done cycle"}, 32'(done_cyc[0]), 32'(t));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " beta_addr"}, beta_addr, 32'd0);
    check({tag, " beta_rd"}, 32'(beta_rd), 32'd0);
    check({tag, " point_x"}, 32'(point_x), 32'd0);
    check({tag, " point_y"}, 32'(point_y), 32'd0);
    check({tag, " laser_on"}, 32'(laser_on), 32'd0);
    check({tag, " point_valid"}, 32'(point_valid), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] hdr;
    logic [15:0] dwell;
    int          stall0;
    int          exp_err;
    int          exp_done;
  } vec_t;

  vec_t tab [7];

  // Guard against a hang anywhere in the run.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    int ne, nd, T1;

    tab[0] = '{"basic",        32'd2,          16'd3, 0,  0, 1};
    tab[1] = '{"backpressure", 32'd2,          16'd3, 10, 0, 1};
    tab[2] = '{"count0",       32'd0,          16'd3, 0,  1, 0};
    tab[3] = '{"count1025",    32'd1025,       16'd3, 0,  1, 0};
    tab[4] = '{"upper bits",   32'hFFFF_0001,  16'd0, 2,  0, 1};
    tab[5] = '{"single",       32'd1,          16'd1, 0,  0, 1};
    tab[6] = '{"max count",    32'd1024,       16'd0, 0,  0, 1};

    for (int i = 0; i < MEMW; i++) mem[i] = $urandom();
    mem[1] = 32'h8123_0456;
    mem[2] = 32'h0FFF_0000;
    for (int i = 0; i < 4; i++) mem1[i] = $urandom();
    clear_stalls();

    // Asynchronous reset, checked before any clock edge.
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("reset");
    step();
    step();
    reset_n = 1'b1;
    step();

    // Table-driven list scenarios.
    for (int i = 0; i < 7; i++) begin
      clear_stalls();
      stall_tab[0] = tab[i].stall0;
      run_list(tab[i].name, tab[i].hdr, tab[i].dwell, ne, nd);
      check({tab[i].name, " error pulses"}, 32'(ne), 32'(tab[i].exp_err));
      check({tab[i].name, " done pulses"}, 32'(nd), 32'(tab[i].exp_done));
      if (i == 0) begin
        check("basic first point", (acc_pt.size() > 0) ? acc_pt[0] : 32'hFFFF_FFFF, 32'h0112_3456);
        check("basic second point", (acc_pt.size() > 1) ? acc_pt[1] : 32'hFFFF_FFFF, 32'h00FF_F000);
        check("basic third read addr", (rd_addr.size() > 2) ? rd_addr[2] : 32'hFFFF_FFFF, 32'h0000_0408);
      end
    end

    // stop in PRESENT of point 1 of 4.
    clear_stalls();
    stall_tab[1] = 5;
    mem[0] = 32'd4;
    clear_logs();
    dwell = 16'd1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 200 && !(point_valid && acc_count == 1); k++) step();
    check("stop reached point 1", 32'(point_valid && acc_count == 1), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop point_valid", 32'(point_valid), 32'd0);
    check("stop busy", 32'(busy), 32'd0);
    repeat (6) step();
    check("stop no done", 32'(done_cyc.size()), 32'd0);
    check("stop no further reads", 32'(rd_addr.size()), 32'd3);

    // stop and start together in IDLE.
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    check("stop+start busy", 32'(busy), 32'd0);
    check("stop+start beta_rd", 32'(beta_rd), 32'd0);
    step();
    check("stop+start no read", 32'(rd_addr.size()), 32'd3);

    clear_stalls();
    run_list("replay", 32'd4, 16'd1, ne, nd);

    // Reset during WAIT_PT, after a start pulse while busy.
    mem[0] = 32'd4;
    clear_logs();
    dwell = 16'd2;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy before second start", 32'(busy), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && !(beta_rd && beta_addr == BASE + 32'd4); k++) step();
    check("reached point 0 read", 32'(beta_rd), 32'd1);
    step();
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("mid-read reset");
    check("start while busy ignored", 32'(rd_addr.size()), 32'd2);
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();
    check("late data not presented", 32'(valid_cnt), 32'd0);
    check("idle after reset busy", 32'(busy), 32'd0);
    check("no reads after reset", 32'(rd_addr.size()), 32'd2);
    check("no pulses after reset", 32'(done_cyc.size() + err_cyc.size()), 32'd0);

    // Latency-1 instance: dwell 0, three points, addresses wrap past 2^32.
    mem1[0] = 32'd3;
    dwell1  = 16'd0;
    step();
    start1 = 1'b1;
    T1 = cyc + 1;
    step();
    start1 = 1'b0;
    for (int k = 0; k < 40 && busy1; k++) step();
    step();
    check("lat1 accepted count", 32'(acc1_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < acc1_cyc.size()) begin
        check($sformatf("lat1 accept %0d cycle", i), 32'(acc1_cyc[i]), 32'(T1 + 4 + 4 * i));
        check($sformatf("lat1 point %0d fields", i), acc1_pt[i],
              32'({mem1[i + 1][31], mem1[i + 1][27:16], mem1[i + 1][11:0]}));
      end
    end
    check("lat1 done count", 32'(done1_cyc.size()), 32'd1);
    if (done1_cyc.size() > 0) check("lat1 done cycle", 32'(done1_cyc[0]), 32'(T1 + 14));
    check("lat1 read count", 32'(rd1_addr.size()), 32'd4);
    if (rd1_addr.size() == 4) begin
      check("lat1 header addr", rd1_addr[0], 32'hFFFF_FFF8);
      check("lat1 pt0 addr", rd1_addr[1], 32'hFFFF_FFFC);
      check("lat1 pt1 addr wraps", rd1_addr[2], 32'h0000_0000);
      check("lat1 pt2 addr", rd1_addr[3], 32'h0000_0004);
    end

    // Randomized lists.
    for (int r = 0; r < 8; r++) begin
      int          cnt;
      logic [31:0] hdr;
      logic [15:0] d;
      cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1025, 1100)) : int'($urandom_range(0, 20));
      hdr = {16'($urandom()), 16'(cnt)};
      d   = 16'($urandom_range(0, 4));
      for (int i = 1; i <= 21; i++) mem[i] = $urandom();
      for (int i = 0; i < 24; i++) stall_tab[i] = int'($urandom_range(0, 3));
      run_list($sformatf("rand%0d", r), hdr, d, ne, nd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/projector_point_sequencer.md
# projector_point_sequencer

Reads a point list that the Beta processor has written into shared memory and presents each point to the laser galvo/DAC stage with a valid/ready handshake and a programmable dwell per point. It sits between the Beta shared-memory read port and the projector output path. It is the reading side of the shared-memory interface: the camera sequencer writes Beta memory through `beta_addr`/`beta_din`, and this block reads it back out through `beta_addr`/`beta_dout`.

## Interface
- `BASE_ADDR`, 32'h0000_0400: byte address of the list header word (word-aligned).
- `MAX_POINTS`, 1024: largest legal point count.
- `RD_LATENCY`, 2: cycles from the `beta_rd` cycle to valid `beta_dout`; must be ≥1.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to play the list. Ignored unless `busy`=0.
- `stop` in 1: synchronous abort. Returns the block to IDLE the next cycle with no `done` pulse.
- `dwell` in 16: number of hold cycles after each point is accepted. Sampled on `start`.
- `beta_addr` out 32: byte read address.
- `beta_rd` out 1: one-cycle read strobe.
- `beta_dout` in 32: read data from memory.
- `point_x` out 12: X coordinate.
- `point_y` out 12: Y coordinate.
- `laser_on` out 1: beam enable for the presented point.
- `point_valid` out 1: point fields are valid.
- `point_ready` in 1: downstream accepts the point.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last point's dwell completes.
- `error` out 1: one-cycle pulse when the header is illegal.

## Operation
- Header word, read at `BASE_ADDR`: `count` = `beta_dout[15:0]`.
- Point word i (0-based), read at `BASE_ADDR + 4*(i+1)`:
  - `laser_on` = bit 31
  - `point_x` = bits [27:16]
  - `point_y` = bits [11:0]
  - All other bits are ignored.
- Only one read is outstanding at a time.
- States and transitions:
  - IDLE → RD_HDR on `start`.
  - RD_HDR: assert `beta_rd` for one cycle → WAIT_HDR.
  - WAIT_HDR: wait RD_LATENCY cycles, then capture `count`.
    - `count`=0 or `count`>MAX_POINTS → pulse `error` → IDLE.
    - Otherwise → RD_PT with i=0.
  - RD_PT: one-cycle `beta_rd` → WAIT_PT.
  - WAIT_PT: capture the point into output registers → PRESENT.
  - PRESENT: `point_valid`=1 until `point_ready` is sampled high → DWELL.
  - DWELL: count down the `dwell` value latched at start.
    - At zero, if i=`count`−1 → pulse `done` → IDLE.
    - Otherwise increment i → RD_PT.
    - `dwell`=0 spends exactly one DWELL cycle.
- Point index is 16 bits. Address arithmetic is 32-bit and wraps modulo 2^32 with no error.
- Output fields hold their last values between points and after `done`. `point_valid` is the only qualifier.
- `stop` has priority over every transition and over `done`/`error`.
  - `stop` and `start` in the same IDLE cycle: stay in IDLE.
- `reset_n` low at any time, including mid-read: all state clears immediately. A read in flight is discarded.

## Timing
- Reset values:
  - `beta_addr`=0, `beta_rd`=0
  - `point_x`=0, `point_y`=0, `laser_on`=0, `point_valid`=0
  - `busy`=0, `done`=0, `error`=0
- `start` sampled at edge T → `beta_rd`=1 and `beta_addr`=BASE_ADDR during cycle T+1.
- Read data is sampled at the edge RD_LATENCY cycles after the `beta_rd` cycle. `point_valid` rises the following cycle.
- Handshake:
  - `point_valid` is held with stable fields until accepted.
  - Acceptance happens at the edge where `point_valid`&`point_ready`=1.
  - `point_valid` is low the cycle after acceptance.
- Per-point period with RD_LATENCY=L, zero backpressure and dwell D: 1 (RD_PT) + L (WAIT_PT) + 1 (PRESENT) + max(D,1) (DWELL) cycles.
- `done` rises the cycle after the final DWELL cycle. `busy` falls in that same cycle.
- `error` rises L+1 cycles after the `beta_rd` header cycle. `busy` falls with it.

## Test plan
- Basic list: header `count`=2, points 32'h8123_0456 and 32'h0FFF_0000, `dwell`=3, `point_ready` tied high.
  - Required: reads at 0x400, 0x404, 0x408.
  - First point presented as x=0x123, y=0x456, `laser_on`=1; second as x=0xFFF, y=0, `laser_on`=0.
  - Each point held 3 DWELL cycles; one `done` pulse; `busy` then 0.
- Backpressure: hold `point_ready` low for 10 cycles on point 0.
  - Required: `point_valid` stays high with fields unchanged for 10 cycles.
  - No further `beta_rd` until acceptance.
- Illegal header: `count`=0, then `count`=1025.
  - Required: each case gives exactly one `error` pulse, no point reads, and `point_valid` never asserts.
- `stop` asserted in PRESENT of point 1 of 4.
  - Required: `point_valid`=0 and `busy`=0 the next cycle; no `done`.
  - A new `start` replays from address 0x400.
- `reset_n` pulsed low during WAIT_PT, with `start` pulsed while `busy`=1 beforehand.
  - Required: every output returns to its reset value asynchronously.
  - The late read data is not presented.
  - The `start` pulsed while busy had no effect.
- `dwell`=0 with RD_LATENCY=1 and `count`=3.
  - Required: point accepted every 4 cycles; `done` 1 cycle after the third acceptance.
